// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, stall encoding and load opcodes shared by the ID/EX/MEM stages.
package mem_stage_pkg;
  localparam int EX_TO_MEM_WD = 83;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;
  localparam int STALL_BUS    = 6;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  typedef enum logic [2:0] {
    MEM_NONE = 3'b000,
    LD_W     = 3'b001,
    LD_B     = 3'b010,
    LD_BU    = 3'b011,
    LD_H     = 3'b100,
    LD_HU    = 3'b101
  } mem_op_e;
  typedef struct packed {
    logic [2:0]  mem_op;
    logic [3:0]  data_ram_sel;
    logic [31:0] ex_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/halfword of a load word and sign- or zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = addr[1] ? (addr[0] ? rdata[31:24] : rdata[23:16])
                          : (addr[0] ? rdata[15:8]  : rdata[7:0]);
  assign w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  // NONE and any unused code fall through to the full word
  always_comb
    data = (mem_op == LD_B)  ? {{24{w_byte[7]}}, w_byte}  :
           (mem_op == LD_BU) ? {24'd0, w_byte}            :
           (mem_op == LD_H)  ? {{16{w_half[15]}}, w_half} :
           (mem_op == LD_HU) ? {16'd0, w_half}            : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register with stall-safe load data capture and WB/forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);
  ex_mem_t     r_bus;
  logic        r_first;
  logic [31:0] r_hold;
  logic        w_load;
  logic [31:0] w_rdata;
  logic [31:0] w_aligned;
  logic [31:0] w_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus   <= '0;
      r_first <= 1'b0;
      r_hold  <= '0;
    end else begin
      if (stall[3] == NO_STOP) r_bus <= ex_to_mem_bus;
      else if (stall[4] == NO_STOP) r_bus <= '0;
      r_first <= (stall[3] == NO_STOP);
      if (r_first) r_hold <= data_sram_rdata;
    end
  end
  // SRAM data is only valid in the first MEM cycle; afterwards the captured copy is used
  assign w_rdata = r_first ? data_sram_rdata : r_hold;
  assign w_load  = r_bus.data_ram_en && (r_bus.data_ram_wen == 4'd0) && r_bus.sel_rf_res;
  mem_load_align u_align (
    .mem_op (r_bus.mem_op),
    .addr   (r_bus.ex_result[1:0]),
    .rdata  (w_rdata),
    .data   (w_aligned)
  );
  assign w_wdata       = w_load ? w_aligned : r_bus.ex_result;
  assign mem_to_wb_bus = {r_bus.ex_pc, r_bus.rf_we, r_bus.rf_waddr, w_wdata};
  assign mem_to_rf_bus = mem_to_wb_bus[MEM_TO_RF_WD-1:0];
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of load alignment, stall hold/bubble, forwarding and reset.
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [82:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  int n_cmp = 0;
  int n_err = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [82:0] mk(input logic [2:0] op, input logic [31:0] pc, input logic ld,
                                     input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {op, 4'hF, pc, ld, 4'h0, ld, we, wa, res};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; ex_to_mem_bus = '0; data_sram_rdata = 32'hA5A5A5A5;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_wb", mem_to_wb_bus, 70'd0);
    chk("reset_rf", {32'd0, mem_to_rf_bus}, 70'd0);

    ex_to_mem_bus = mk(LD_B, 32'h100, 1'b1, 1'b1, 5'd3, 32'h1001);
    tick(); data_sram_rdata = 32'h12F45678; #1;
    chk("ld_b_a1", mem_to_wb_bus, {32'h100, 1'b1, 5'd3, 32'h00000056});
    ex_to_mem_bus = mk(LD_B, 32'h104, 1'b1, 1'b1, 5'd3, 32'h1002);
    tick(); #1;
    chk("ld_b_a2", mem_to_wb_bus, {32'h104, 1'b1, 5'd3, 32'hFFFFFFF4});
    ex_to_mem_bus = mk(LD_BU, 32'h108, 1'b1, 1'b1, 5'd4, 32'h1003);
    tick(); #1;
    chk("ld_bu_a3", mem_to_wb_bus, {32'h108, 1'b1, 5'd4, 32'h00000012});

    ex_to_mem_bus = mk(LD_HU, 32'h10C, 1'b1, 1'b1, 5'd6, 32'h2002);
    tick(); data_sram_rdata = 32'h8001FFFF; #1;
    chk("ld_hu_a2", mem_to_wb_bus, {32'h10C, 1'b1, 5'd6, 32'h00008001});
    ex_to_mem_bus = mk(LD_H, 32'h110, 1'b1, 1'b1, 5'd6, 32'h2002);
    tick(); #1;
    chk("ld_h_a2", mem_to_wb_bus, {32'h110, 1'b1, 5'd6, 32'hFFFF8001});
    ex_to_mem_bus = mk(LD_H, 32'h114, 1'b1, 1'b1, 5'd6, 32'h2003);
    tick(); #1;
    chk("ld_h_a3_odd", mem_to_wb_bus, {32'h114, 1'b1, 5'd6, 32'hFFFF8001});
    ex_to_mem_bus = mk(LD_H, 32'h118, 1'b1, 1'b1, 5'd6, 32'h2000);
    tick(); #1;
    chk("ld_h_a0", mem_to_wb_bus, {32'h118, 1'b1, 5'd6, 32'hFFFFFFFF});

    ex_to_mem_bus = mk(LD_W, 32'h120, 1'b1, 1'b1, 5'd7, 32'h3000);
    tick(); data_sram_rdata = 32'hDEADBEEF; #1;
    chk("ld_w", mem_to_wb_bus, {32'h120, 1'b1, 5'd7, 32'hDEADBEEF});
    stall = 6'b011000;
    ex_to_mem_bus = mk(LD_W, 32'h999, 1'b1, 1'b1, 5'd9, 32'h9);
    for (int k = 0; k < 3; k++) begin
      tick(); data_sram_rdata = 32'h0; #1;
      chk($sformatf("ld_w_hold%0d", k), mem_to_wb_bus, {32'h120, 1'b1, 5'd7, 32'hDEADBEEF});
    end
    stall = 6'b001000;
    tick(); #1;
    chk("bubble_wb", mem_to_wb_bus, 70'd0);
    chk("bubble_rf", {32'd0, mem_to_rf_bus}, 70'd0);

    stall = 6'b0;
    ex_to_mem_bus = mk(MEM_NONE, 32'h200, 1'b0, 1'b1, 5'd5, 32'h10);
    tick(); #1;
    chk("alu_wb", mem_to_wb_bus, {32'h200, 1'b1, 5'd5, 32'h10});
    chk("alu_rf", {32'd0, mem_to_rf_bus}, {32'd0, 1'b1, 5'd5, 32'h10});
    ex_to_mem_bus = {LD_W, 4'hF, 32'h204, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h4000};
    tick(); #1;
    chk("store", mem_to_wb_bus, {32'h204, 1'b0, 5'd0, 32'h4000});
    ex_to_mem_bus = mk(MEM_NONE, 32'h208, 1'b1, 1'b1, 5'd8, 32'h4001);
    tick(); data_sram_rdata = 32'hCAFEF00D; #1;
    chk("none_as_ldw", mem_to_wb_bus, {32'h208, 1'b1, 5'd8, 32'hCAFEF00D});

    ex_to_mem_bus = mk(LD_W, 32'h300, 1'b1, 1'b1, 5'd10, 32'h5000);
    tick(); data_sram_rdata = 32'h11112222; #1;
    chk("pre_rst_ldw", mem_to_wb_bus, {32'h300, 1'b1, 5'd10, 32'h11112222});
    stall = 6'b011000;
    tick(); tick(); data_sram_rdata = 32'h0; #1;
    chk("pre_rst_hold", mem_to_wb_bus, {32'h300, 1'b1, 5'd10, 32'h11112222});
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rst_in_stall_wb", mem_to_wb_bus, 70'd0);
    chk("rst_in_stall_rf", {32'd0, mem_to_rf_bus}, 70'd0);
    stall = 6'b0;
    ex_to_mem_bus = mk(LD_W, 32'h304, 1'b1, 1'b1, 5'd11, 32'h5004);
    tick(); data_sram_rdata = 32'h33334444; #1;
    chk("post_rst_ldw", mem_to_wb_bus, {32'h304, 1'b1, 5'd11, 32'h33334444});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
